// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with run/halt/error FSM; optional retired-instruction counter under PC_INSTRET_EN
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    input  logic        imem_error_i,
    input  logic        ill_instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    output logic [1:0]  state_o,
    output logic [63:0] instret_o
);
    typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, ERR_ADR = 2'd2, ERR_INS = 2'd3} state_t;
    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    assign pc_plus4_o = pc + 32'd4;
    assign pc_o       = pc;
    assign state_o    = state;
    assign valid_o    = (state == RUN);
    // next state and next PC by the RUN priority list; every other state is terminal
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        if (state == RUN) begin
            if (imem_error_i)                     state_nx = ERR_ADR;
            else if (ill_instr_i)                 state_nx = ERR_INS;
            else if (stall_i)                     pc_nx    = pc;
            else if (halt_i)                      state_nx = HALT;
            else if (redirect_i && |redirect_pc_i[1:0]) state_nx = ERR_ADR;
            else if (redirect_i)                  pc_nx    = redirect_pc_i;
            else                                  pc_nx    = pc_plus4_o;
        end
    end
    // PC and state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc    <= RESET_PC;
            state <= RUN;
        end else begin
            pc    <= pc_nx;
            state <= state_nx;
        end
    end
`ifdef PC_INSTRET_EN
    logic [63:0] instret;
    logic        commit;
    // halt and misaligned-redirect instructions still complete, so only stalls and faults block commit
    assign commit    = (state == RUN) && !(stall_i || imem_error_i || ill_instr_i);
    assign instret_o = instret;
    // retired-instruction counter, wraps at 2^64
    always_ff @(posedge clk_i) begin
        if (rst_i)       instret <= 64'd0;
        else if (commit) instret <= instret + 64'd1;
    end
`else
    assign instret_o = 64'd0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, redirect = 1'b0, halt = 1'b0, imem_err = 1'b0, ill = 1'b0;
    logic [31:0] rpc = 32'd0;
    logic [31:0] pc_a, pc4_a, pc_b, pc4_b;
    logic        valid_a, valid_b;
    logic [1:0]  st_a, st_b;
    logic [63:0] ir_a, ir_b;
    logic        zero = 1'b0;
    logic [31:0] zero32 = 32'd0;
    int          n_cmp = 0, n_err = 0;
    longint      ir = 0;
`ifdef PC_INSTRET_EN
    localparam bit IR_ON = 1'b1;
`else
    localparam bit IR_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    pc_sequencer u_a (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(rpc), .halt_i(halt), .imem_error_i(imem_err), .ill_instr_i(ill),
        .pc_o(pc_a), .pc_plus4_o(pc4_a), .valid_o(valid_a), .state_o(st_a), .instret_o(ir_a)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFF8)) u_b (
        .clk_i(clk), .rst_i(rst), .stall_i(zero), .redirect_i(zero),
        .redirect_pc_i(zero32), .halt_i(zero), .imem_error_i(zero), .ill_instr_i(zero),
        .pc_o(pc_b), .pc_plus4_o(pc4_b), .valid_o(valid_b), .state_o(st_b), .instret_o(ir_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_a(input string tag, input logic [31:0] pc, input logic [1:0] st);
        chk({tag, " pc"}, {32'd0, pc_a}, {32'd0, pc});
        chk({tag, " pc4"}, {32'd0, pc4_a}, {32'd0, pc + 32'd4});
        chk({tag, " state"}, {62'd0, st_a}, {62'd0, st});
        chk({tag, " valid"}, {63'd0, valid_a}, {63'd0, st == 2'd0});
        chk({tag, " instret"}, ir_a, IR_ON ? 64'(ir) : 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        ir = 0;
    endtask

    initial begin
        cyc();
        cyc();
        rst = 1'b0;
        chk_a("reset", 32'h0, 2'd0);
        chk("b reset pc", {32'd0, pc_b}, {32'd0, 32'hFFFF_FFF8});
        // free run: A counts up, B wraps through zero
        for (int i = 1; i <= 4; i++) begin
            cyc();
            ir++;
            chk_a($sformatf("run%0d", i), 32'(4 * i), 2'd0);
            chk($sformatf("b run%0d pc", i), {32'd0, pc_b}, {32'd0, 32'hFFFF_FFF8 + 32'(4 * i)});
            if (i == 1) chk("b pc4 wrap", {32'd0, pc4_b}, 64'd0);
        end
        chk("b instret", ir_b, IR_ON ? 64'd4 : 64'd0);
        // stall beats redirect
        stall = 1'b1; redirect = 1'b1; rpc = 32'h100;
        cyc();
        chk_a("stall+redir", 32'h10, 2'd0);
        stall = 1'b0;
        cyc();
        ir++;
        chk_a("redir", 32'h100, 2'd0);
        // stall beats halt
        redirect = 1'b0; halt = 1'b1; stall = 1'b1;
        cyc();
        chk_a("stall+halt", 32'h100, 2'd0);
        // misaligned redirect: instruction commits, target faults
        halt = 1'b0; stall = 1'b0; redirect = 1'b1; rpc = 32'h102;
        cyc();
        ir++;
        chk_a("misalign", 32'h100, 2'd2);
        rpc = 32'h200;
        cyc();
        cyc();
        chk_a("err_adr frozen", 32'h100, 2'd2);
        redirect = 1'b0;
        do_reset();
        chk_a("reset from err", 32'h0, 2'd0);
        cyc();
        ir++;
        chk_a("post reset run", 32'h4, 2'd0);
        // illegal instruction beats stall
        ill = 1'b1; stall = 1'b1;
        cyc();
        chk_a("ill", 32'h4, 2'd3);
        ill = 1'b0; stall = 1'b0;
        cyc();
        chk_a("err_ins frozen", 32'h4, 2'd3);
        // reset applied with requests active
        halt = 1'b1; imem_err = 1'b1;
        do_reset();
        chk_a("reset overrides", 32'h0, 2'd0);
        cyc();
        chk_a("imem beats halt", 32'h0, 2'd2);
        halt = 1'b0; imem_err = 1'b0;
        do_reset();
        halt = 1'b1;
        cyc();
        ir++;
        chk_a("halt", 32'h0, 2'd1);
        halt = 1'b0; redirect = 1'b1; rpc = 32'h40;
        cyc();
        chk_a("halt frozen", 32'h0, 2'd1);
        redirect = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter stage of the single-cycle core, directly upstream of the fetch/decode stage. Holds the architectural PC, drives it to instruction memory and decode every cycle, and computes the next PC from sequential increment, stall, or redirect requests from execute. A small run/halt/error state machine freezes the PC on halt, on instruction-memory faults, on illegal instructions and on misaligned redirects. An optional retired-instruction counter is included.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk_i  input  1  core clock; all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- stall_i  input  1  hold PC this cycle; current instruction does not commit
- redirect_i  input  1  taken branch/jump from execute
- redirect_pc_i  input  32  redirect target
- halt_i  input  1  current instruction is a halt/ecall
- imem_error_i  input  1  instruction memory fault at pc_o (from fetch)
- ill_instr_i  input  1  decode found an undefined opcode
- pc_o  output  32  current PC (registered)
- pc_plus4_o  output  32  pc_o + 4, combinational, mod 2^32 (link value)
- valid_o  output  1  1 when state is RUN
- state_o  output  2  0 RUN, 1 HALT, 2 ERR_ADR, 3 ERR_INS
- instret_o  output  64  retired-instruction count (see Configuration)

## Operation
- States: RUN, HALT, ERR_ADR, ERR_INS. HALT and both ERR states are terminal; only reset exits them. PC is frozen in all non-RUN states; inputs ignored.
- In RUN, per-cycle priority (highest first):
  - imem_error_i: -> ERR_ADR, PC held.
  - ill_instr_i: -> ERR_INS, PC held.
  - stall_i: PC held, stay RUN; halt_i/redirect_i ignored this cycle.
  - halt_i: -> HALT, PC held at the halt instruction.
  - redirect_i with redirect_pc_i[1:0] != 0: -> ERR_ADR, PC held at the redirecting instruction.
  - redirect_i aligned: pc_o <= redirect_pc_i.
  - otherwise: pc_o <= pc_o + 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
- Commit condition: state RUN and none of stall_i, imem_error_i, ill_instr_i. Halt instruction and misaligned-redirect instruction count as committed (they complete; the fault is on the target).
- valid_o = (state_o == RUN).

## Timing
- Reset (rst_i high at an edge): pc_o = RESET_PC, state_o = 0 (RUN), valid_o = 1, instret_o = 0. Reset overrides all other inputs, including mid-stall or in a terminal state.
- pc_o, state_o, instret_o registered; next value visible one cycle after the deciding edge. pc_plus4_o and valid_o combinational from registers, zero extra latency.
- Redirect latency: redirect_i asserted in cycle N -> pc_o = target in cycle N+1.
- Error/halt latency: state_o changes at the edge ending the faulting cycle; pc_o remains the faulting instruction's PC thereafter.
- Simultaneous events resolved strictly by the priority list above; no event is queued for a later cycle.

## Configuration
- PC_INSTRET_EN defined: 64-bit instret counter increments by 1 on every commit, wraps at 2^64; not incremented in non-RUN states.
- PC_INSTRET_EN undefined: counter omitted; instret_o tied to 64'd0.

## Test plan
- Reset then 4 free-running cycles, no requests -> pc_o 0x0,0x4,0x8,0xC,0x10; pc_plus4_o tracks +4; instret_o = 4 (macro on).
- At pc_o=0x8 assert redirect_i, redirect_pc_i=0x100 together with stall_i, then redirect alone -> pc_o 0x8 held one cycle, then 0x100; instret_o increments only on the second.
- redirect_pc_i=0x102 at pc_o=0x20 -> state_o=2, pc_o stays 0x20 indefinitely, valid_o=0; assert rst_i one cycle -> pc_o=RESET_PC, state_o=0.
- halt_i and imem_error_i together at pc_o=0x40 -> state_o=2 (error wins), instret_o unchanged; separate run with halt_i alone -> state_o=1, instret_o +1.
- RESET_PC=0xFFFF_FFF8, run 3 cycles -> pc_o 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4.
- Build without PC_INSTRET_EN, repeat first scenario -> instret_o = 0 throughout, PC sequence identical.
